chunk_assembler: RTL and testbench
==================================

# chunk_assembler

Forward-direction strip assembler for the upscaler datapath. It accepts a raster pixel stream, one pixel per cycle, for a strip of CELL_SIZE video rows × CHUNK_SIZE·CELL_SIZE columns. It buffers the strip and presents it as one processing chunk of CHUNK_SIZE cells, each CELL_SIZE×CELL_SIZE. It sits between the video input path and the per-cell processing array; the inverse chunk transposer on the output side undoes its layout.

## Interface
- CELL_SIZE, 2, cell edge in pixels (≥2)
- CHUNK_SIZE, 64, cells per chunk (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_pixel  in  pixel  input pixel (pixel type from types.sv)
- in_valid  in  1  in_pixel valid
- in_last  in  1  marks final pixel of a strip
- in_ready  out  1  assembler can accept in_pixel
- processing_chunk  out  pixel[CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0]  assembled chunk, indexed [cell][row][col]
- out_valid  out  1  processing_chunk valid
- out_ready  in  1  consumer accepts chunk
- align_err  out  1  sticky: in_last mismatched with strip end

## Operation
- Strip width W = CHUNK_SIZE·CELL_SIZE. Input order: row r = 0..CELL_SIZE-1, column x = 0..W-1 within each row.
- An input beat is accepted when in_valid && in_ready. The accepted pixel is written to processing_chunk[x / CELL_SIZE][r][x % CELL_SIZE].
- Counters:
  - col_cnt counts 0..W-1 and wraps to 0 at W-1, incrementing row_cnt.
  - row_cnt counts 0..CELL_SIZE-1.
  - Strip end is col_cnt==W-1 && row_cnt==CELL_SIZE-1. At strip end both counters clear.
- Bank states (per bank): FILL → FULL on the accepted strip-end beat. FULL → FILL on the out handshake (out_valid && out_ready).
- Single-bank build:
  - in_ready = (state==FILL).
  - out_valid = (state==FULL).
- Chunk contents are held stable while out_valid is high and out_ready is low.
- in_last checking:
  - in_last=1 on a non-strip-end beat sets align_err and resynchronises: counters clear and the partial strip is discarded (bank stays FILL).
  - in_last=0 on a strip-end beat sets align_err, but the strip is still completed normally.
- align_err clears only on reset.
- in_valid while in_ready is low is ignored; no pixel is written.

## Timing
- Reset values: out_valid=0, align_err=0, in_ready=1 in the cycle after reset, counters 0, all banks FILL.
- Chunk buffer contents are undefined after reset and are not cleared.
- Latency: out_valid rises on the clock edge that accepts the strip-end beat, so it is visible the cycle after that beat.
- Single-bank build: in_ready drops in that same cycle. in_ready returns high the cycle after the out handshake.
- Throughput:
  - Without ping-pong: one strip per (CELL_SIZE·W + 1) cycles minimum.
  - With ping-pong: one strip per CELL_SIZE·W cycles when out_ready is held high.
- Reset asserted mid-strip or mid-handshake discards all data. Outputs take their reset values on the next edge.
- Simultaneous strip-end write and out handshake (ping-pong build only): both take effect in the same cycle and no beat is lost.

## Configuration
- CHUNK_ASSEMBLER_PINGPONG_EN defined:
  - Two chunk banks with wr_bank and rd_bank pointers.
  - in_ready = (wr_bank state==FILL); out_valid = (rd_bank state==FULL).
  - Input fills one bank while the other is presented.
  - On strip end, wr_bank toggles; on the out handshake, rd_bank toggles.
  - Both banks FULL: in_ready=0.
- Undefined: one bank with the single-bank rules above, at half the storage.

## Structure
- Shared package (types.sv): the pixel typedef already lives there. Add chunk_t (pixel[CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0]) as a parameterised typedef or macro, plus the bank_state_e enum {FILL, FULL}.
- One natural sub-module, chunk_bank: a single write-addressed chunk register with FILL/FULL state, instantiated once or twice depending on the macro.
- The top level holds the counters, in_last checking and bank pointers.

## Test plan
Bench uses CELL_SIZE=2, CHUNK_SIZE=4 (W=8); pixel value = 16·r + x.
- Single strip, out_ready=1 → out_valid one cycle after the 16th beat; processing_chunk[2][1][1] = 16·1 + 5 = 21; processing_chunk[0][0][0] = 0.
- out_ready held 0 for 10 cycles after out_valid → chunk stable and out_valid held. Without ping-pong, in_ready=0 throughout. With ping-pong, in_ready stays 1 until the second strip completes, then drops to 0.
- Ping-pong build, three back-to-back strips with out_ready=1 → three out_valid pulses 16 cycles apart, with no in_ready deassertion.
- in_last on beat 5 → align_err=1 next cycle. The following 16 beats form a correct chunk; processing_chunk[0][0][0] is pixel 0 of the new strip.
- Strip end without in_last → align_err=1 and the chunk is still delivered.
- Reset asserted at beat 9 → out_valid=0 and in_ready=1 after reset; the next 16 beats produce one correct chunk.

Source files
------------

// File: rtl/chunk_assembler_pkg.sv
// chunk_assembler_pkg: pixel type and bank state shared by the strip assembler
package chunk_assembler_pkg;
  localparam int PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel;
  typedef enum logic {FILL, FULL} bank_state_e;
endpackage

// File: rtl/chunk_assembler_bank.sv
// chunk_bank: one write-addressed chunk register with FILL/FULL state
module chunk_bank
  import chunk_assembler_pkg::*;
#(
  parameter int CELL_SIZE = 2,
  parameter int CHUNK_SIZE = 64,
  localparam int CW = CHUNK_SIZE > 1 ? $clog2(CHUNK_SIZE) : 1,
  localparam int SW = $clog2(CELL_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_cell_i,
  input  logic [SW-1:0] wr_row_i,
  input  logic [SW-1:0] wr_col_i,
  input  pixel          wr_pixel_i,
  input  logic          fill_done_i,
  input  logic          drain_i,
  output logic          full_o,
  output pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] chunk_o
);
  bank_state_e state_q, state_d;
  pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] chunk_q;

  always_comb state_d = (state_q == FILL && fill_done_i) ? FULL :
                        (state_q == FULL && drain_i) ? FILL : state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else state_q <= state_d;
  end

  // Storage is deliberately not reset; only the state says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en_i) chunk_q[wr_cell_i][wr_row_i][wr_col_i] <= wr_pixel_i;
  end

  assign full_o = state_q == FULL;
  assign chunk_o = chunk_q;
endmodule

// File: rtl/chunk_assembler.sv
// chunk_assembler: raster strip to [cell][row][col] chunk; CHUNK_ASSEMBLER_PINGPONG_EN selects two banks
module chunk_assembler
  import chunk_assembler_pkg::*;
#(
  parameter int CELL_SIZE = 2,
  parameter int CHUNK_SIZE = 64
) (
  input  logic clk,
  input  logic reset,
  input  pixel in_pixel,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] processing_chunk,
  output logic out_valid,
  input  logic out_ready,
  output logic align_err
);
  localparam int W = CHUNK_SIZE * CELL_SIZE;
  localparam int XW = $clog2(W + 1);
  localparam int CW = CHUNK_SIZE > 1 ? $clog2(CHUNK_SIZE) : 1;
  localparam int SW = $clog2(CELL_SIZE);
`ifdef CHUNK_ASSEMBLER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  typedef pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] chunk_t;

  logic [XW-1:0] col_cnt_q, col_cnt_d;
  logic [SW-1:0] row_cnt_q, row_cnt_d;
  logic align_err_q, align_err_d;
  logic accept, col_end, strip_end, drain;
  logic [NB-1:0] wsel, rsel, full;
  chunk_t bank_chunk [NB];

  assign accept = in_valid && in_ready;
  assign col_end = col_cnt_q == XW'(W - 1);
  assign strip_end = col_end && row_cnt_q == SW'(CELL_SIZE - 1);
  assign drain = out_valid && out_ready;

  // A stray in_last resynchronises the counters to the start of a fresh strip.
  always_comb begin
    col_cnt_d = !accept ? col_cnt_q : (col_end || in_last) ? '0 : col_cnt_q + 1'b1;
    row_cnt_d = !accept ? row_cnt_q : (strip_end || in_last) ? '0 : row_cnt_q + SW'(col_end);
    align_err_d = align_err_q | (accept && (in_last != strip_end));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      align_err_q <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      align_err_q <= align_err_d;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    chunk_bank #(.CELL_SIZE(CELL_SIZE), .CHUNK_SIZE(CHUNK_SIZE)) u_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (accept && wsel[g]),
      .wr_cell_i  (CW'(col_cnt_q / XW'(CELL_SIZE))),
      .wr_row_i   (row_cnt_q),
      .wr_col_i   (SW'(col_cnt_q % XW'(CELL_SIZE))),
      .wr_pixel_i (in_pixel),
      .fill_done_i(accept && strip_end && wsel[g]),
      .drain_i    (drain && rsel[g]),
      .full_o     (full[g]),
      .chunk_o    (bank_chunk[g])
    );
  end

`ifdef CHUNK_ASSEMBLER_PINGPONG_EN
  logic wr_bank_q, rd_bank_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_q ^ (accept && strip_end);
      rd_bank_q <= rd_bank_q ^ drain;
    end
  end
  assign wsel = {wr_bank_q, !wr_bank_q};
  assign rsel = {rd_bank_q, !rd_bank_q};
  assign processing_chunk = bank_chunk[rd_bank_q];
`else
  assign wsel = 1'b1;
  assign rsel = 1'b1;
  assign processing_chunk = bank_chunk[0];
`endif

  assign in_ready = |(wsel & ~full);
  assign out_valid = |(rsel & full);
  assign align_err = align_err_q;
endmodule

// File: tb/tb_chunk_assembler.sv
// tb_chunk_assembler: directed scoreboard bench for chunk_assembler (CELL_SIZE=2, CHUNK_SIZE=4)
module tb_chunk_assembler;
  import chunk_assembler_pkg::*;
  localparam int CS = 2;
  localparam int CK = 4;
  localparam int W = CS * CK;
`ifdef CHUNK_ASSEMBLER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  typedef pixel [CK-1:0][CS-1:0][CS-1:0] chunk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pixel in_pixel = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, align_err;
  chunk_t processing_chunk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;
  chunk_t exp_q[$];
  int hs_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  chunk_assembler #(.CELL_SIZE(CS), .CHUNK_SIZE(CK)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_pixel        (in_pixel),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .processing_chunk(processing_chunk),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .align_err       (align_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic chunk_t mk(input int off);
    chunk_t c;
    for (int r = 0; r < CS; r++)
      for (int x = 0; x < W; x++)
        c[x / CS][r][x % CS] = pixel'(off + 16 * r + x);
    return c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pixel = pixel'(v);
    in_last = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    stalls += n;
    chk("ready_timeout", n < 50, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_strip(input int off, input logic last_ok);
    for (int r = 0; r < CS; r++)
      for (int x = 0; x < W; x++) begin
        if (r == CS - 1 && x == W - 1) exp_q.push_back(mk(off));
        send(off + 16 * r + x, (r == CS - 1 && x == W - 1) ? last_ok : 1'b0);
      end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_chunk", 1, 0);
      else chk("chunk", processing_chunk, exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_align_err", align_err, 0);

    out_ready = 1'b1;
    send_strip(0, 1'b1);
    chk("s1_out_valid", out_valid, 1);
    chk("s1_in_ready", in_ready, PP);
    chk("s1_p211", processing_chunk[2][1][1], 21);
    chk("s1_p000", processing_chunk[0][0][0], 0);
    tick();
    chk("s1_drained_valid", out_valid, 0);
    chk("s1_drained_ready", in_ready, 1);

    out_ready = 1'b0;
    send_strip(64, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, PP);
      chk("hold_chunk", processing_chunk, mk(64));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_drained", out_valid, 0);

    for (int x = 0; x < 5; x++) send(96 + x, x == 4);
    chk("al_err_set", align_err, 1);
    chk("al_no_chunk", out_valid, 0);
    send_strip(128, 1'b1);
    chk("al_p000", processing_chunk[0][0][0], 128);
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r1_align_err", align_err, 0);
    send_strip(160, 1'b0);
    chk("nolast_err", align_err, 1);
    chk("nolast_valid", out_valid, 1);
    tick();

    for (int i = 0; i < 9; i++) send(32 + i, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r2_out_valid", out_valid, 0);
    chk("r2_in_ready", in_ready, 1);
    chk("r2_align_err", align_err, 0);
    send_strip(200, 1'b1);
    chk("r2_p000", processing_chunk[0][0][0], 200);
    tick();

`ifdef CHUNK_ASSEMBLER_PINGPONG_EN
    hs_cyc.delete();
    stalls = 0;
    send_strip(0, 1'b1);
    send_strip(32, 1'b1);
    send_strip(64, 1'b1);
    tick();
    chk("pp_pulses", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("pp_gap1", hs_cyc[1] - hs_cyc[0], 16);
      chk("pp_gap2", hs_cyc[2] - hs_cyc[1], 16);
    end
    chk("pp_stalls", stalls, 0);
`endif

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
